// File: rtl/display_pkg.sv
// Shared constants for the 4-digit 7-segment display path: segment patterns,
// bus polarity/bit order, and the capture FSM state type.
package display_pkg;

  localparam int SEG_W     = 7;
  localparam int NIB_W     = 4;
  localparam int DIGITS    = 4;

  // Segment bus is active high with segment a on the MSB and g on the LSB.
  localparam logic SEG_ON    = 1'b1;
  localparam int   SEG_A_BIT = 6;
  localparam int   SEG_G_BIT = 0;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h1F;
  localparam logic [SEG_W-1:0] SEG_C = 7'h4E;
  localparam logic [SEG_W-1:0] SEG_D = 7'h3D;
  localparam logic [SEG_W-1:0] SEG_E = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_F = 7'h47;

  // WAIT0 doubles as "expecting digit 0"; Dk expects digit k.
  typedef enum logic [1:0] {
    WAIT0 = 2'd0,
    D1    = 2'd1,
    D2    = 2'd2,
    D3    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to hex nibble decoder; ok is low for any
// pattern that is not one of the 16 hex glyphs.
module seg7_decode
  import display_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [NIB_W-1:0] nibble,
  output logic             ok
);

  logic [SEG_W-1:0] seg_ord;
  logic [SEG_W-1:0] seg_ah;

  // Normalise to a-on-MSB, active-high before matching glyphs.
  assign seg_ord = (SEG_A_BIT > SEG_G_BIT) ? seg : {<<{seg}};
  assign seg_ah  = SEG_ON ? seg_ord : ~seg_ord;

  always_comb begin
    nibble = '0;
    ok     = 1'b1;
    case (seg_ah)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: ok     = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Reassembles the 16-bit word from a multiplexed 4-digit 7-segment bus.
// Optional frame-stability filter enabled by defining DISPLAY_CAPTURE_STABLE_EN.
module display_capture
  import display_pkg::*;
#(
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  en,
  input  logic [6:0]  seg,
  output logic [15:0] data,
  output logic        valid,
  output logic        err
);

  if (STABLE_FRAMES < 2 || STABLE_FRAMES > 15) begin : g_bad_param
    $error("display_capture: STABLE_FRAMES must be in 2..15");
  end

  cap_state_e       state_p1, state_nx;
  logic [NIB_W-1:0] nib_p1 [DIGITS];

  logic [NIB_W-1:0] dec_nib_p0;
  logic             dec_ok_p0;
  logic             onehot_p0;
  logic [1:0]       digit_p0;
  logic             good_p0, bad_p0;
  logic [1:0]       kx;
  logic             latch, frame_done, err_nx, load;
  logic [15:0]      word_p0;

  seg7_decode u_dec (
    .seg    (seg),
    .nibble (dec_nib_p0),
    .ok     (dec_ok_p0)
  );

  // ---- stage p0: classify the live sample and decide the frame step ----
  always_comb begin
    onehot_p0 = 1'b1;
    digit_p0  = 2'd0;
    case (en)
      4'b0001: digit_p0 = 2'd0;
      4'b0010: digit_p0 = 2'd1;
      4'b0100: digit_p0 = 2'd2;
      4'b1000: digit_p0 = 2'd3;
      default: onehot_p0 = 1'b0;
    endcase
  end

  assign good_p0 = onehot_p0 & dec_ok_p0;
  assign bad_p0  = (en != 4'b0000) & ~good_p0;
  assign kx      = state_p1;
  assign word_p0 = {dec_nib_p0, nib_p1[2], nib_p1[1], nib_p1[0]};

  always_comb begin
    state_nx   = state_p1;
    latch      = 1'b0;
    frame_done = 1'b0;
    err_nx     = 1'b0;
    if (bad_p0) begin
      err_nx   = 1'b1;
      state_nx = WAIT0;
    end else if (good_p0) begin
      if (state_p1 == WAIT0) begin
        if (digit_p0 == 2'd0) begin
          latch    = 1'b1;
          state_nx = D1;
        end
      end else if (digit_p0 == kx) begin
        latch = 1'b1;
        if (kx == 2'd3) begin
          frame_done = 1'b1;
          state_nx   = WAIT0;
        end else begin
          state_nx = cap_state_e'(kx + 2'd1);
        end
      end else if (digit_p0 == kx - 2'd1) begin
        latch = 1'b1;
      end else if (digit_p0 == 2'd0) begin
        err_nx   = 1'b1;
        latch    = 1'b1;
        state_nx = D1;
      end else begin
        err_nx   = 1'b1;
        state_nx = WAIT0;
      end
    end
  end

`ifdef DISPLAY_CAPTURE_STABLE_EN
  localparam logic [3:0] SF_CNT = 4'(STABLE_FRAMES);

  logic [3:0]  cnt_p1, cnt_nx;
  logic [15:0] prev_p1;

  // A zero count means no frame since reset/error, so the next frame starts a run.
  always_comb begin
    cnt_nx = cnt_p1;
    if (err_nx) begin
      cnt_nx = 4'd0;
    end else if (frame_done) begin
      if (cnt_p1 == 4'd0 || word_p0 != prev_p1) cnt_nx = 4'd1;
      else if (cnt_p1 < SF_CNT)                 cnt_nx = cnt_p1 + 4'd1;
    end
  end

  assign load = frame_done && (cnt_nx == SF_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1  <= 4'd0;
      prev_p1 <= '0;
    end else begin
      cnt_p1 <= cnt_nx;
      if (frame_done) prev_p1 <= word_p0;
    end
  end
`else
  assign load = frame_done;
`endif

  // ---- stage p1: registered state, nibbles and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= WAIT0;
      for (int i = 0; i < DIGITS; i++) nib_p1[i] <= '0;
      data     <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_p1 <= state_nx;
      if (latch) nib_p1[digit_p0] <= dec_nib_p0;
      if (load)  data <= word_p0;
      valid <= load;
      err   <= err_nx;
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// Self-checking bench for display_capture: directed scenarios followed by
// random bus traffic, all checked against a frame-level reference model.
module tb_display_capture;

  localparam int SF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic [6:0]  seg;
  logic [15:0] data;
  logic        valid;
  logic        err;

  always #5 clk = ~clk;

  display_capture #(.STABLE_FRAMES(SF)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .seg   (seg),
    .data  (data),
    .valid (valid),
    .err   (err)
  );

  logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: which digit the frame expects next, the digits seen so far.
  int          m_next;
  int          m_dig [4];
  logic [15:0] m_data;
  logic        m_valid, m_err;
  int          m_run;
  logic [15:0] m_last;

  function automatic int glyph_value(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (pat[i] == s) return i;
    return -1;
  endfunction

  function automatic int which_digit(input logic [3:0] e);
    for (int i = 0; i < 4; i++) if (e == 4'(1 << i)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_next = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_data = 16'h0000; m_valid = 1'b0; m_err = 1'b0;
    m_run = 0; m_last = 16'h0000;
  endtask

  task automatic frame_complete(input logic [15:0] w);
`ifdef DISPLAY_CAPTURE_STABLE_EN
    if (m_run == 0 || w != m_last) m_run = 1;
    else if (m_run < SF)           m_run = m_run + 1;
    m_last = w;
    if (m_run == SF) begin m_valid = 1'b1; m_data = w; end
`else
    m_valid = 1'b1;
    m_data  = w;
`endif
  endtask

  task automatic model_step();
    int d, v;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (en == 4'b0000) return;
    d = which_digit(en);
    v = glyph_value(seg);
    if (d < 0 || v < 0) begin
      m_err = 1'b1; m_next = 0;
    end else if (m_next == 0) begin
      if (d == 0) begin m_dig[0] = v; m_next = 1; end
    end else if (d == m_next) begin
      m_dig[d] = v;
      if (d == 3) begin
        m_next = 0;
        frame_complete({4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])});
      end else m_next = m_next + 1;
    end else if (d == m_next - 1) begin
      m_dig[d] = v;
    end else if (d == 0) begin
      m_err = 1'b1; m_dig[0] = v; m_next = 1;
    end else begin
      m_err = 1'b1; m_next = 0;
    end
    if (m_err) m_run = 0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] e, input logic [6:0] s);
    en  = e;
    seg = s;
    model_step();
    @(posedge clk);
    #1;
    check("valid", {15'd0, valid}, {15'd0, m_valid});
    check("err",   {15'd0, err},   {15'd0, m_err});
    check("data",  data, m_data);
  endtask

  task automatic frame(input logic [15:0] w);
    for (int i = 0; i < 4; i++) step(4'(1 << i), pat[w[4*i +: 4]]);
  endtask

  initial begin
    rst = 1'b1; en = 4'b0000; seg = 7'h00;
    model_reset();
    step(4'b0000, 7'h00);
    step(4'b0001, 7'h7E);
    rst = 1'b0;

    frame(16'hBDE3);
`ifndef DISPLAY_CAPTURE_STABLE_EN
    check("data_bde3", data, 16'hBDE3);
`endif

    step(4'b0100, pat[7]);
    step(4'b1000, pat[9]);
    frame(16'h1234);
`ifndef DISPLAY_CAPTURE_STABLE_EN
    check("data_1234", data, 16'h1234);
`endif

    step(4'b0001, pat[5]); step(4'b0001, pat[5]); step(4'b0001, pat[5]);
    step(4'b0000, 7'h00);  step(4'b0010, pat[6]); step(4'b0000, 7'h7F);
    step(4'b0100, pat[7]); step(4'b0000, 7'h00);  step(4'b1000, pat[8]);
`ifndef DISPLAY_CAPTURE_STABLE_EN
    check("data_8765", data, 16'h8765);
`endif

    step(4'b0001, pat[1]); step(4'b0010, 7'h00);
    check("err_seg00", {15'd0, err}, 16'd1);
    step(4'b0011, pat[1]);
    check("err_twohot", {15'd0, err}, 16'd1);
    frame(16'hCAFE);

    step(4'b0001, pat[0]); step(4'b0010, pat[1]); step(4'b1000, pat[3]);
    check("err_skip", {15'd0, err}, 16'd1);
    frame(16'h0F0F);

    step(4'b0001, pat[9]); step(4'b0010, pat[9]);
    rst = 1'b1;
    step(4'b0100, pat[9]);
    check("data_rst", data, 16'h0000);
    rst = 1'b0;
    frame(16'h4321);

    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      rst = (r == 0);
      if (r < 700)      step(4'(1 << (c % 4)), pat[$urandom_range(0, 15)]);
      else if (r < 800) step(4'b0000, 7'($urandom_range(0, 127)));
      else if (r < 870) step(4'(1 << $urandom_range(0, 3)), pat[$urandom_range(0, 15)]);
      else if (r < 930) step(4'(1 << $urandom_range(0, 3)), 7'($urandom_range(0, 127)));
      else              step(4'($urandom_range(0, 15)), pat[$urandom_range(0, 15)]);
    end
    rst = 1'b0;
    for (int f = 0; f < 20; f++) frame(16'($urandom));

`ifdef DISPLAY_CAPTURE_STABLE_EN
    frame(16'h1111); check("stab_f1", {15'd0, valid}, 16'd0);
    frame(16'h2222); check("stab_f2", {15'd0, valid}, 16'd0);
    frame(16'h2222); check("stab_f3", {15'd0, valid}, 16'd1);
    check("stab_d3", data, 16'h2222);
    frame(16'h2222); check("stab_f4", {15'd0, valid}, 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/display_capture.md
# display_capture

Receive-side counterpart of the 4-digit multiplexed 7-segment driver. It samples the one-hot digit enable and segment bus, decodes each active-high segment pattern back to a hex nibble, and reassembles the 16-bit word shown on the display. It reports each complete frame with a one-cycle `valid` pulse and each protocol violation with a one-cycle `err` pulse. It sits in loopback and self-test paths, and behind any display-bus snooper.

## Interface

- `STABLE_FRAMES`, default 2: consecutive identical frames required before output update. Used only with `DISPLAY_CAPTURE_STABLE_EN`; legal range 2..15.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  4  digit enable, active high; one-hot selects digit 0..3, all-zero means blanking.
- `seg`  in  7  segment bus, active high, bit6=a … bit0=g.
- `data`  out  16  last accepted word, digit 3 in [15:12], digit 0 in [3:0].
- `valid`  out  1  one-cycle pulse when `data` is (re)loaded.
- `err`  out  1  one-cycle pulse on protocol or pattern violation.

## Operation

**Decode map** (seg hex → nibble):
- 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7
- 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F
- Any other pattern is invalid.

**Sample classification**, evaluated each cycle:
- Blank (`en`=0): ignored in every state. No state change, no error.
- Bad: `en` not one-hot, or `seg` invalid while `en` is one-hot.
- Good: one-hot `en` with a valid pattern.

**FSM** (states WAIT0, D1, D2, D3; Dk means "digits 0..k-1 captured, expecting digit k"):
- WAIT0:
  - Good digit 0: latch nib0, go to D1.
  - Good other digit: ignored (mid-frame entry).
  - Bad: pulse `err`, stay.
- Dk, good digit k: latch nibk, advance.
- D3, good digit 3: load `data`={nib3,nib2,nib1,nib0} (with the digit-3 nibble just decoded), pulse `valid`, go to WAIT0.
- Dk, good digit k-1 (hold/repeat): re-latch nib(k-1), stay.
- Dk, good digit 0 when k≠1: pulse `err`, latch nib0, go to D1 (restart).
- Dk, any other good digit: pulse `err`, go to WAIT0.
- Dk, bad sample: pulse `err`, go to WAIT0.
- `valid` and `err` are never asserted in the same cycle.
- Nibble registers are not cleared on error; only the FSM state governs frame assembly.

## Timing

- Inputs are used combinationally in the sampling cycle; no input register.
- `data`, `valid`, `err` are registered. Each changes on the clock edge that samples the triggering `en`/`seg`, so it is visible the cycle after the sample is presented.
- Minimum frame length is 4 cycles, matching a driver that advances one digit per clock. Back-to-back frames each produce `valid`, every 4 cycles.
- Reset values:
  - `data`=0000, `valid`=0, `err`=0.
  - State WAIT0, nibble registers 0, match counter 0.
- `rst` mid-frame discards the partial frame. The first good digit 0 after `rst` deasserts starts a new frame.

## Configuration

`DISPLAY_CAPTURE_STABLE_EN`:
- Defined:
  - A completed frame is compared against the previous completed frame.
  - Match counter: set to 1 on mismatch or first frame; incremented on match; saturates at `STABLE_FRAMES`. Any `err` clears it to 0.
  - `data` loads and `valid` pulses only on frames where the counter equals `STABLE_FRAMES` after update. A steady display therefore yields `valid` on every frame from the `STABLE_FRAMES`-th onward.
  - The previous-frame register resets to 0.
- Undefined: every completed frame loads `data` and pulses `valid`. The counter and previous-frame register are absent.

## Structure

- Package `display_pkg`:
  - The 16 segment-pattern constants (shared with the driver).
  - FSM state enum.
  - Segment polarity/bit-order constants.
- Sub-module `seg7_decode`: combinational, `seg[6:0]` → `nibble[3:0]` plus `ok`. Instantiated once in the top.

## Test plan

- Drive `en`=1,2,4,8 with `seg`=79,4F,3D,1F → `valid` one cycle after the digit-3 sample, `data`=BDE3, `err`=0.
- Enter mid-frame at digit 2, then a full frame for 1234 → no `err`, one `valid`, `data`=1234.
- Digit 0 held 3 cycles, blank cycles between digits, then digits 1..3 → `valid`, correct word, no `err`.
- `seg`=00 on digit 1, or `en`=0011 → `err` pulse, no `valid`, `data` unchanged. Next clean frame is accepted.
- Sequence 0,1,3 → `err` on the digit-3 sample, FSM returns to WAIT0. Assert `rst` during D2 → outputs 0, next full frame accepted.
- With `DISPLAY_CAPTURE_STABLE_EN`, `STABLE_FRAMES`=2, frames 1111, 2222, 2222, 2222 → `valid` only after the 3rd and 4th frames, `data`=2222.
